// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider.
//   DIV_WIDTH  : default operand / quotient / remainder width
//   DIV_CNT_W  : iteration counter width for the default width
//   state_t    : sequencing FSM encoding
//   cnt_bits() : counter width needed to hold the value w
//   cla_carry(): 4-bit carry-lookahead carry into position pos (0..4)
package div_pkg;

  localparam int DIV_WIDTH = 64;

  function automatic int cnt_bits(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int DIV_CNT_W = cnt_bits(DIV_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Flattened lookahead equations for one 4-wide group. pos = 4 yields the
  // group carry-out; with cin = 0 that is the group generate term.
  function automatic logic cla_carry(input logic [3:0] g, input logic [3:0] p,
                                     input logic cin, input int unsigned pos);
    logic c;
    case (pos)
      0: c = cin;
      1: c = g[0] | (p[0] & cin);
      2: c = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
      3: c = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
           | (p[2] & p[1] & p[0] & cin);
      default: c = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                 | (p[3] & p[2] & p[1] & g[0])
                 | (p[3] & p[2] & p[1] & p[0] & cin);
    endcase
    return c;
  endfunction

endpackage

// File: rtl/div_64_iter_sub_cla.sv
// Combinational N-bit subtractor, diff = a - b computed as a + ~b + 1.
// Bits are grouped by 4 with a lookahead carry per group; groups are in turn
// grouped by 4 with a second lookahead level. The operands are padded up to
// a whole number of groups (pad bits propagate, never generate) so the
// carry-out of the padded adder equals the carry-out of the N-bit one.
//   a, b   : N-bit unsigned operands
//   diff   : a - b modulo 2^N
//   borrow : 1 when a < b (inverse of the adder carry-out)
module sub_cla
  import div_pkg::*;
#(
  parameter int N = DIV_WIDTH + 1
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow
);

  localparam int NG  = (N + 3) / 4;   // real 4-bit groups
  localparam int M   = NG * 4;        // padded bit width
  localparam int NB  = (NG + 3) / 4;  // second-level blocks
  localparam int NGP = NB * 4;        // padded group count

  logic [M-1:0]   g;
  logic [M-1:0]   p;
  logic [N-1:0]   c;   // carry into each real bit
  logic [NGP-1:0] gg;
  logic [NGP-1:0] gp;
  logic [NG-1:0]  cg;  // carry into each real group
  logic [NB:0]    cb;  // carry into each block; cb[NB] is the carry-out

  genvar gi;
  generate
    for (gi = 0; gi < M; gi++) begin : g_bit
      if (gi < N) begin : g_real
        assign g[gi] = a[gi] & ~b[gi];
        assign p[gi] = a[gi] ^ ~b[gi];
      end else begin : g_pad
        assign g[gi] = 1'b0;
        assign p[gi] = 1'b1;
      end
    end

    for (gi = 0; gi < NGP; gi++) begin : g_grp
      if (gi < NG) begin : g_real
        assign gg[gi] = cla_carry(g[4*gi +: 4], p[4*gi +: 4], 1'b0, 4);
        assign gp[gi] = &p[4*gi +: 4];
      end else begin : g_pad
        assign gg[gi] = 1'b0;
        assign gp[gi] = 1'b1;
      end
    end

    // The +1 of two's complement negation enters as the carry-in.
    assign cb[0] = 1'b1;
    for (gi = 0; gi < NB; gi++) begin : g_blk
      assign cb[gi+1] = cla_carry(gg[4*gi +: 4], gp[4*gi +: 4], cb[gi], 4);
    end

    for (gi = 0; gi < NG; gi++) begin : g_gc
      assign cg[gi] = cla_carry(gg[4*(gi/4) +: 4], gp[4*(gi/4) +: 4],
                                cb[gi/4], gi % 4);
    end

    for (gi = 0; gi < N; gi++) begin : g_bc
      assign c[gi] = cla_carry(g[4*(gi/4) +: 4], p[4*(gi/4) +: 4],
                               cg[gi/4], gi % 4);
    end
  endgenerate

  assign diff   = p[N-1:0] ^ c;
  assign borrow = ~cb[NB];

endmodule

// File: rtl/div_64_iter.sv
// Iterative radix-2 restoring unsigned divider, one operation in flight.
//   clk, rst          : rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready : operand handshake (dividend, divisor)
//   out_valid/out_ready : result handshake (quotient, remainder, div_by_zero)
// A non-zero divisor takes WIDTH iteration cycles, one trial subtraction per
// cycle; a zero divisor produces all-ones / dividend after one cycle.
module div_64_iter
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = cnt_bits(WIDTH);

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   q_reg, q_next;       // dividend shifts out, quotient shifts in
  logic [WIDTH-1:0]   r_reg, r_next;       // partial remainder, always < divisor
  logic [WIDTH-1:0]   dvsr_reg, dvsr_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               dbz_reg, dbz_next;

  logic [WIDTH:0]     r_shift;
  logic [WIDTH-1:0]   trial_diff;
  logic               diff_msb_unused;     // zero whenever the trial succeeds
  logic               borrow;

  // One extra bit so a shifted remainder >= 2^(WIDTH-1)*2 still compares
  // correctly against divisors with the MSB set.
  assign r_shift = {r_reg, q_reg[WIDTH-1]};

  sub_cla #(
    .N(WIDTH + 1)
  ) u_sub (
    .a      (r_shift),
    .b      ({1'b0, dvsr_reg}),
    .diff   ({diff_msb_unused, trial_diff}),
    .borrow (borrow)
  );

  always_comb begin
    state_next = state_reg;
    q_next     = q_reg;
    r_next     = r_reg;
    dvsr_next  = dvsr_reg;
    cnt_next   = cnt_reg;
    dbz_next   = dbz_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          if (divisor != '0) begin
            q_next    = dividend;
            r_next    = '0;
            dvsr_next = divisor;
            cnt_next  = CNT_W'(WIDTH);
            dbz_next  = 1'b0;
          end else begin
            // Result is known immediately; spend a single BUSY cycle so
            // out_valid rises one edge after the accept.
            q_next   = '1;
            r_next   = dividend;
            dbz_next = 1'b1;
            cnt_next = CNT_W'(1);
          end
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (!dbz_reg) begin
          q_next = {q_reg[WIDTH-2:0], ~borrow};
          r_next = borrow ? r_shift[WIDTH-1:0] : trial_diff;
        end
        cnt_next = cnt_reg - CNT_W'(1);
        if (cnt_reg == CNT_W'(1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      q_reg     <= '0;
      r_reg     <= '0;
      dvsr_reg  <= '0;
      cnt_reg   <= '0;
      dbz_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      q_reg     <= q_next;
      r_reg     <= r_next;
      dvsr_reg  <= dvsr_next;
      cnt_reg   <= cnt_next;
      dbz_reg   <= dbz_next;
    end
  end

  assign in_ready    = (state_reg == IDLE);
  assign out_valid   = (state_reg == DONE);
  assign quotient    = q_reg;
  assign remainder   = r_reg;
  assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_div_64_iter.sv
// Directed bench for div_64_iter: expected results are queued when operands
// are accepted and popped when the divider presents a result.
module tb_div_64_iter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] dividend = '0;
  logic [63:0] divisor = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] quotient;
  logic [63:0] remainder;
  logic        div_by_zero;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [63:0] q;
    logic [63:0] r;
    logic        dbz;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  div_64_iter dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b);
    exp_t e;
    if (b == 64'd0) begin
      e.q = '1;
      e.r = a;
      e.dbz = 1'b1;
    end else begin
      e.q = a / b;
      e.r = a % b;
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present operands until accepted; the expected result is queued then.
  task automatic send(input logic [63:0] dd, input logic [63:0] dv, input string tag);
    int guard = 0;
    while (!in_ready && guard < 200) begin
      step();
      guard++;
    end
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    dividend = dd;
    divisor  = dv;
    sb.push_back(model(dd, dv));
    step();
    in_valid = 1'b0;
  endtask

  // Called just after the accept edge; counts edges until out_valid.
  task automatic wait_result(input int exp_lat, input string tag);
    int   lat = 0;
    logic ready_seen = 1'b0;
    while (!out_valid && lat < 200) begin
      if (in_ready) ready_seen = 1'b1;
      step();
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_busy_in_ready"}, 64'(ready_seen), 64'd0);
  endtask

  task automatic compare_result(input string tag);
    exp_t e;
    e.q = '0;
    e.r = '0;
    e.dbz = 1'b0;
    check({tag, "_sb_entries"}, 64'(sb.size()), 64'd1);
    if (sb.size() > 0) e = sb.pop_front();
    check({tag, "_quotient"}, quotient, e.q);
    check({tag, "_remainder"}, remainder, e.r);
    check({tag, "_div_by_zero"}, 64'(div_by_zero), 64'(e.dbz));
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_out_valid_after"}, 64'(out_valid), 64'd0);
    check({tag, "_in_ready_after"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [63:0] rd;
    logic [63:0] rv;
    logic        valid_seen;

    // Reset state
    step();
    step();
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_quotient", quotient, 64'd0);
    check("rst_remainder", remainder, 64'd0);
    check("rst_div_by_zero", 64'(div_by_zero), 64'd0);
    rst = 1'b0;
    step();

    // 100 / 7, then hold the result for 10 cycles with out_ready low
    send(64'd100, 64'd7, "d100_7");
    wait_result(64, "d100_7");
    compare_result("d100_7");
    for (int i = 0; i < 10; i++) begin
      step();
      check("hold_out_valid", 64'(out_valid), 64'd1);
      check("hold_quotient", quotient, 64'd14);
      check("hold_remainder", remainder, 64'd2);
      check("hold_in_ready", 64'(in_ready), 64'd0);
    end
    handshake("d100_7");
    check("post_hs_quotient_kept", quotient, 64'd14);

    // Divide by zero
    send(64'd5, 64'd0, "d5_0");
    wait_result(1, "d5_0");
    compare_result("d5_0");
    handshake("d5_0");

    // Extremes, including a divisor with the MSB set
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, "dmax_1");
    wait_result(64, "dmax_1");
    compare_result("dmax_1");
    handshake("dmax_1");

    send(64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, "dmax_msb");
    wait_result(64, "dmax_msb");
    check("dmax_msb_rem_direct", remainder, 64'h7FFF_FFFF_FFFF_FFFF);
    compare_result("dmax_msb");
    handshake("dmax_msb");

    // Dividend smaller than divisor, then a request held through DONE
    send(64'd3, 64'd10, "d3_10");
    wait_result(64, "d3_10");
    compare_result("d3_10");
    in_valid  = 1'b1;
    dividend  = 64'd1000;
    divisor   = 64'd10;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("b2b_out_valid_after", 64'(out_valid), 64'd0);
    check("b2b_not_accepted_in_done", 64'(in_ready), 64'd1);
    sb.push_back(model(64'd1000, 64'd10));
    step();
    in_valid = 1'b0;
    check("b2b_accepted", 64'(in_ready), 64'd0);
    wait_result(64, "d1000_10");
    check("d1000_10_q_direct", quotient, 64'd100);
    compare_result("d1000_10");
    handshake("d1000_10");

    // A few random operands over a spread of divisor magnitudes
    for (int k = 0; k < 4; k++) begin
      rd = {$urandom, $urandom};
      rv = {$urandom, $urandom} >> $urandom_range(0, 63);
      send(rd, rv, "rand");
      wait_result((rv == 64'd0) ? 1 : 64, "rand");
      compare_result("rand");
      handshake("rand");
    end

    // Asynchronous reset 30 cycles into BUSY aborts the operation
    send(64'd12345, 64'd67, "abort");
    repeat (30) step();
    #3 rst = 1'b1;
    #1;
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_quotient", quotient, 64'd0);
    sb.delete();
    step();
    rst = 1'b0;
    valid_seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (out_valid) valid_seen = 1'b1;
      step();
    end
    check("abort_no_result", 64'(valid_seen), 64'd0);

    send(64'd81, 64'd9, "d81_9");
    wait_result(64, "d81_9");
    check("d81_9_q_direct", quotient, 64'd9);
    compare_result("d81_9");
    handshake("d81_9");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
